// File: rtl/id_issue_queue_pkg.sv
// Shared definitions for the decode-stage issue queue: instruction field
// positions and the forwarding-source record.
package id_issue_queue_pkg;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int REG_W  = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // wdata is sized for the widest supported datapath; narrower users truncate.
    localparam int FWD_DATA_MAX = 64;

    typedef struct packed {
        logic                    we;
        logic [REG_W-1:0]        waddr;
        logic [FWD_DATA_MAX-1:0] wdata;
        logic                    pend;
    } fwd_src_t;
endpackage

// File: rtl/id_issue_queue_operand_resolver.sv
// One operand's priority forwarding mux: lowest-index matching source wins,
// a pending winner raises a hazard, register zero is always 0 and never stalls.
module operand_resolver
    import id_issue_queue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]        rf_data_i,
    input  fwd_src_t [NUM_FWD-1:0]   fwd_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     hazard_o
);
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        // Walk from oldest to youngest so the lowest index overrides last.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_i[i].we && fwd_i[i].waddr == addr_i) begin
                data_o   = DATA_W'(fwd_i[i].wdata);
                hazard_o = fwd_i[i].pend;
            end
        end
        if (addr_i == REG_ZERO) begin
            data_o   = '0;
            hazard_o = 1'b0;
        end
    end
endmodule

// File: rtl/id_issue_queue.sv
// Instruction queue between IF and issue: circular buffer, head operand
// resolution through forwarding sources, hazard hold and flush.
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_valid_i,
    output logic                        push_ready_o,
    input  logic [DATA_W-1:0]           push_instr_i,
    input  logic [DATA_W-1:0]           push_pc4_i,
    output logic                        iss_valid_o,
    input  logic                        iss_ready_i,
    output logic [DATA_W-1:0]           iss_instr_o,
    output logic [DATA_W-1:0]           iss_pc4_o,
    output logic [DATA_W-1:0]           iss_rdata1_o,
    output logic [DATA_W-1:0]           iss_rdata2_o,
    output logic [4:0]                  rf_raddr1_o,
    output logic [4:0]                  rf_raddr2_o,
    input  logic [DATA_W-1:0]           rf_rdata1_i,
    input  logic [DATA_W-1:0]           rf_rdata2_i,
    input  logic [NUM_FWD-1:0]          fwd_we_i,
    input  logic [5*NUM_FWD-1:0]        fwd_waddr_i,
    input  logic [DATA_W*NUM_FWD-1:0]   fwd_wdata_i,
    input  logic [NUM_FWD-1:0]          fwd_pend_i,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        hazard_stall_o,
    output logic [CNT_W-1:0]            hazard_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DEPTH-1:0][DATA_W-1:0] instr_q, pc4_q;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]             hcnt_q, hcnt_d;

    fwd_src_t [NUM_FWD-1:0] fwd;
    logic                   empty, haz1, haz2, hazard, push_fire, pop_fire;
    logic [DATA_W-1:0]      head_instr;

    for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
        assign fwd[g].we    = fwd_we_i[g];
        assign fwd[g].waddr = fwd_waddr_i[5*g +: 5];
        assign fwd[g].wdata = FWD_DATA_MAX'(fwd_wdata_i[DATA_W*g +: DATA_W]);
        assign fwd[g].pend  = fwd_pend_i[g];
    end

    assign head_instr  = instr_q[rd_ptr_q];
    assign rf_raddr1_o = head_instr[RS_MSB:RS_LSB];
    assign rf_raddr2_o = head_instr[RT_MSB:RT_LSB];
    assign iss_instr_o = head_instr;
    assign iss_pc4_o   = pc4_q[rd_ptr_q];

    operand_resolver #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_res_rs (
        .addr_i(rf_raddr1_o), .rf_data_i(rf_rdata1_i), .fwd_i(fwd),
        .data_o(iss_rdata1_o), .hazard_o(haz1)
    );
    operand_resolver #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_res_rt (
        .addr_i(rf_raddr2_o), .rf_data_i(rf_rdata2_i), .fwd_i(fwd),
        .data_o(iss_rdata2_o), .hazard_o(haz2)
    );

    assign empty          = (cnt_q == '0);
    assign push_ready_o   = (cnt_q != CW'(DEPTH));
    assign hazard         = !empty && (haz1 || haz2);
    assign iss_valid_o    = !empty && !hazard;
    assign hazard_stall_o = hazard;
    assign push_fire      = push_valid_i && push_ready_o && !flush_i;
    assign pop_fire       = iss_valid_o && iss_ready_i && !flush_i;
    assign count_o        = cnt_q;
    assign hazard_cnt_o   = hcnt_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CW'(push_fire) - CW'(pop_fire);
        end
        // Flush does not clear the hazard counter; only reset does.
        if (hazard_stall_o && hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
        end
    end

    // Entry storage carries no reset; contents are only observed when valid.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            pc4_q[wr_ptr_q]   <= push_pc4_i;
        end
    end
endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue with a queue-based reference model checked every cycle.
module tb_id_issue_queue;
    localparam int DATA_W = 32, DEPTH = 4, NUM_FWD = 3, CNT_W = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        flush, pv, ird;
    logic [31:0] pinstr, ppc4;
    logic        push_ready, iss_valid, stall;
    logic [31:0] iss_instr, iss_pc4, rd1, rd2, rf1, rf2;
    logic [4:0]  ra1, ra2;
    logic [2:0]  fwe, fpend;
    logic [14:0] fwaddr;
    logic [95:0] fwdata;
    logic [2:0]  count;
    logic [15:0] hcnt;

    typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
    ent_t        mq[$];
    logic [31:0] issued[$];
    int unsigned m_hcnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // Regfile stand-in: each register holds a value derived from its address.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'h1000_0000 | {27'b0, a};
    endfunction
    assign rf1 = rf_val(ra1);
    assign rf2 = rf_val(ra2);

    id_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .push_valid_i(pv), .push_ready_o(push_ready), .push_instr_i(pinstr), .push_pc4_i(ppc4),
        .iss_valid_o(iss_valid), .iss_ready_i(ird), .iss_instr_o(iss_instr), .iss_pc4_o(iss_pc4),
        .iss_rdata1_o(rd1), .iss_rdata2_o(rd2), .rf_raddr1_o(ra1), .rf_raddr2_o(ra2),
        .rf_rdata1_i(rf1), .rf_rdata2_i(rf2),
        .fwd_we_i(fwe), .fwd_waddr_i(fwaddr), .fwd_wdata_i(fwdata), .fwd_pend_i(fpend),
        .count_o(count), .hazard_stall_o(stall), .hazard_cnt_o(hcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h0, rs, rt, 16'h0};
    endfunction

    // First matching source in priority order decides the operand.
    function automatic void resolve(input logic [4:0] a, output logic [31:0] d, output logic h);
        d = rf_val(a);
        h = 1'b0;
        if (a == 5'd0) begin
            d = '0;
            return;
        end
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwe[i] && fwaddr[5*i +: 5] == a) begin
                d = fwdata[32*i +: 32];
                h = fpend[i];
                return;
            end
        end
    endfunction

    function automatic logic head_hazard();
        logic [31:0] d;
        logic h1, h2;
        if (mq.size() == 0) return 1'b0;
        resolve(mq[0].instr[25:21], d, h1);
        resolve(mq[0].instr[20:16], d, h2);
        return h1 | h2;
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        logic haz, pop, push;
        int n;
        if (rst) begin
            mq.delete();
            m_hcnt = 0;
        end else begin
            n   = mq.size();
            haz = head_hazard();
            if (haz && m_hcnt != 32'hFFFF) m_hcnt++;
            if (flush) mq.delete();
            else begin
                pop  = (n > 0) && !haz && ird;
                push = pv && (n < DEPTH);
                if (pop) begin
                    issued.push_back(mq[0].pc4);
                    void'(mq.pop_front());
                end
                if (push) mq.push_back('{pinstr, ppc4});
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] d1, d2;
        logic h1, h2, haz;
        int n;
        if (!rst) begin
            n = mq.size();
            chk("count", count, n);
            chk("push_ready", push_ready, n < DEPTH);
            chk("hazard_cnt", hcnt, m_hcnt);
            haz = 1'b0;
            if (n > 0) begin
                resolve(mq[0].instr[25:21], d1, h1);
                resolve(mq[0].instr[20:16], d2, h2);
                haz = h1 | h2;
                chk("iss_instr", iss_instr, mq[0].instr);
                chk("iss_pc4", iss_pc4, mq[0].pc4);
                chk("rf_raddr1", ra1, mq[0].instr[25:21]);
                chk("rf_raddr2", ra2, mq[0].instr[20:16]);
                if (!haz) begin
                    chk("iss_rdata1", rd1, d1);
                    chk("iss_rdata2", rd2, d2);
                end
            end
            chk("iss_valid", iss_valid, (n > 0) && !haz);
            chk("hazard_stall", stall, (n > 0) && haz);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush = 0; pv = 0; ird = 0; pinstr = '0; ppc4 = '0;
        fwe = '0; fpend = '0; fwaddr = '0; fwdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hcnt", hcnt, 0);

        // Fill to full, fifth offer rejected, then drain in order.
        for (int k = 0; k < 4; k++) begin
            cyc(); pv = 1; pinstr = mk(1, 2); ppc4 = 32'(4 * (k + 1));
        end
        cyc(); ppc4 = 32'h14;
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_push_ready", push_ready, 0);
        cyc(); pv = 0; ird = 1;
        repeat (4) @(posedge clk);
        #1 ird = 0;
        chk("drain_n", issued.size(), 4);
        chk("drain0", issued[0], 32'h4);
        chk("drain1", issued[1], 32'h8);
        chk("drain2", issued[2], 32'hC);
        chk("drain3", issued[3], 32'h10);

        // Forwarding priority on rs.
        cyc(); pv = 1; pinstr = mk(5, 0); ppc4 = 32'h20;
        cyc(); pv = 0; fwe = 3'b101; fwaddr = {5'd5, 5'd0, 5'd5};
        fwdata = {32'hBBBB, 32'h0, 32'hAAAA};
        @(negedge clk); chk("fwd0_prio", rd1, 32'hAAAA);
        cyc(); fwe = 3'b100;
        @(negedge clk); chk("fwd2", rd1, 32'hBBBB);
        cyc(); fwe = 3'b000;
        @(negedge clk); chk("fwd_none_rf", rd1, 32'h1000_0005);
        cyc(); ird = 1;
        cyc(); ird = 0;
        chk("fwd_issued", issued[issued.size()-1], 32'h20);

        // Pending producer on rt holds the head for two cycles.
        cyc(); pv = 1; pinstr = mk(0, 7); ppc4 = 32'h24;
        cyc(); pv = 0; fwe = 3'b001; fwaddr = {10'b0, 5'd7}; fpend = 3'b001;
        fwdata = {64'b0, 32'h7777};
        @(negedge clk); chk("haz1_valid", iss_valid, 0); chk("haz1_stall", stall, 1);
        cyc();
        @(negedge clk); chk("haz2_valid", iss_valid, 0); chk("haz2_stall", stall, 1);
        cyc(); fpend = 3'b000; ird = 1;
        @(negedge clk);
        chk("haz_cnt2", hcnt, 2);
        chk("haz_rel_valid", iss_valid, 1);
        chk("haz_rel_rt", rd2, 32'h7777);
        cyc(); ird = 0; fwe = 3'b000;
        chk("haz_issued", issued[issued.size()-1], 32'h24);

        // Register zero ignores a pending writer.
        cyc(); pv = 1; pinstr = mk(0, 0); ppc4 = 32'h28;
        cyc(); pv = 0; fwe = 3'b001; fwaddr = '0; fpend = 3'b001;
        @(negedge clk);
        chk("r0_stall", stall, 0);
        chk("r0_valid", iss_valid, 1);
        chk("r0_data", rd1, 0);
        cyc(); ird = 1;
        cyc(); ird = 0; fwe = '0; fpend = '0;

        // Flush with concurrent push and pop.
        for (int k = 0; k < 3; k++) begin
            cyc(); pv = 1; pinstr = mk(1, 2); ppc4 = 32'(32'h30 + 4 * k);
        end
        cyc(); flush = 1; ppc4 = 32'h3C; ird = 1;
        cyc(); flush = 0; pv = 0; ird = 0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_valid", iss_valid, 0);
        chk("flush_hcnt", hcnt, 2);
        chk("flush_no_issue", issued.size(), 7);

        // Full queue with push+pop, then wrap the pointers.
        for (int k = 0; k < 4; k++) begin
            cyc(); pv = 1; pinstr = mk(3, 4); ppc4 = 32'(32'h40 + 4 * k);
        end
        cyc(); ppc4 = 32'h50; ird = 1;
        @(negedge clk);
        chk("fullpp_ready", push_ready, 0);
        chk("fullpp_valid", iss_valid, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(); ppc4 = 32'(32'h54 + 4 * k);
            if (k == 0) begin
                @(negedge clk);
                chk("fullpp_count", count, 3);
            end
        end
        cyc(); pv = 0;
        repeat (3) @(posedge clk);
        #1 ird = 0;
        @(negedge clk);
        chk("wrap_count", count, 0);
        chk("wrap_n", issued.size(), 19);
        for (int j = 0; j < 12; j++) begin
            logic [31:0] e;
            e = (j < 4) ? 32'(32'h40 + 4 * j) : 32'(32'h54 + 4 * (j - 4));
            if (7 + j < issued.size()) chk("wrap_order", issued[7 + j], e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
